// File: rtl/etm_mul16_seq.sv
// Sequential 16x16 multiplier that time-shares one external 8x8 multiplier.
// It has an exact four-phase mode, an ETM-approximate two-phase mode, and a one-phase fast path.
module etm_mul16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        mode_q;
  logic        fast_q;
  logic [1:0]  phase;
  logic [1:0]  last_phase;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic        in_fast;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign in_fast   = (in_a[15:8] == 8'h00) && (in_b[15:8] == 8'h00);

  // The byte pair fed to the shared multiplier depends on mode and phase.
  // It is forced to zero outside MUL so that the shared unit sees no spurious activity.
  always_comb begin
    mul_a = 8'h00;
    mul_b = 8'h00;
    if (state == MUL && !rst) begin
      if (fast_q || phase == 2'd0) begin
        mul_a = a_q[7:0];
        mul_b = b_q[7:0];
      end else if (mode_q) begin
        mul_a = a_q[15:8];
        mul_b = b_q[15:8];
      end else begin
        case (phase)
          2'd1: begin
            mul_a = a_q[7:0];
            mul_b = b_q[15:8];
          end
          2'd2: begin
            mul_a = a_q[15:8];
            mul_b = b_q[7:0];
          end
          default: begin
            mul_a = a_q[15:8];
            mul_b = b_q[15:8];
          end
        endcase
      end
    end
  end

  // Approximate mode places the two byte products side by side, so the cross terms are lost by design.
  always_comb begin
    acc_next = acc;
    if (fast_q) begin
      acc_next = {16'h0000, mul_p};
    end else if (mode_q) begin
      if (phase == 2'd0) acc_next = {acc[31:16], mul_p};
      else               acc_next = {mul_p, acc[15:0]};
    end else begin
      case (phase)
        2'd0:    acc_next = acc + {16'h0000, mul_p};
        2'd1,
        2'd2:    acc_next = acc + {8'h00, mul_p, 8'h00};
        default: acc_next = acc + {mul_p, 16'h0000};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      mode_q     <= 1'b0;
      fast_q     <= 1'b0;
      phase      <= 2'd0;
      last_phase <= 2'd0;
      acc        <= 32'h0000_0000;
      out_c      <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            mode_q     <= in_mode;
            fast_q     <= in_fast;
            last_phase <= in_fast ? 2'd0 : (in_mode ? 2'd1 : 2'd3);
            phase      <= 2'd0;
            acc        <= 32'h0000_0000;
            state      <= MUL;
          end
        end
        MUL: begin
          acc <= acc_next;
          if (phase == last_phase) begin
            out_c <= acc_next;
            state <= DONE;
          end else begin
            phase <= phase + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_etm_mul16_seq.sv
// Bench for etm_mul16_seq: table-driven products and latencies, plus hand-written sequences.
// The hand-written sequences cover byte ordering, backpressure and reset.
module tb_etm_mul16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;

  int checks = 0;
  int passes = 0;

  logic [7:0] seq_a [4];
  logic [7:0] seq_b [4];
  int         seq_n;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [31:0] exp_c;
    int          exp_n;
  } vec_t;

  vec_t vecs [12];

  etm_mul16_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the external 8x8 multiplier.
  assign mul_p = 16'(mul_a) * 16'(mul_b);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic mode,
                               input int hold, output logic [31:0] c, output int lat);
    int  guard;
    bit  stable;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_wait", 32'(guard < 20), 32'd1);
    in_a = a; in_b = b; in_mode = mode; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_mode = ~mode;
    lat = 0;
    seq_n = 0;
    while (!out_valid && lat < 10) begin
      if (seq_n < 4) begin
        seq_a[seq_n] = mul_a;
        seq_b[seq_n] = mul_b;
        seq_n++;
      end
      lat++;
      @(negedge clk);
    end
    c = out_c;
    checkOutput("done_mul_zero", {16'h0, mul_a, mul_b}, 32'h0);
    checkOutput("done_in_ready", 32'(in_ready), 32'd0);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (out_c !== c || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        @(negedge clk);
      end
      checkOutput("backpressure_stable", 32'(stable), 32'd1);
      checkOutput("backpressure_out_c", out_c, c);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("post_handshake_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_handshake_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] c;
    int          lat;

    vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 4};
    vecs[1]  = '{16'h1234, 16'h5678, 1'b1, 32'h060C_1860, 2};
    vecs[2]  = '{16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01, 1};
    vecs[3]  = '{16'h00FF, 16'h00FF, 1'b1, 32'h0000_FE01, 1};
    vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 4};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'hFE01_FE01, 2};
    vecs[6]  = '{16'h0100, 16'h0003, 1'b1, 32'h0000_0000, 2};
    vecs[7]  = '{16'h0100, 16'h0003, 1'b0, 32'h0000_0300, 4};
    vecs[8]  = '{16'h0002, 16'h0003, 1'b0, 32'h0000_0006, 1};
    vecs[9]  = '{16'h00FF, 16'h0100, 1'b0, 32'h0000_FF00, 4};
    vecs[10] = '{16'hABCD, 16'h00EF, 1'b1, 32'h0000_BF63, 2};
    vecs[11] = '{16'hABCD, 16'h00EF, 1'b0, 32'h00A0_6463, 4};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_c", out_c, 32'h0);
    checkOutput("reset_mul", {16'h0, mul_a, mul_b}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("first_cycle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].mode, 0, c, lat);
      checkOutput($sformatf("vec%0d_out_c", i), c, vecs[i].exp_c);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_n));
    end

    // The byte pairs must be presented in the order required by each mode.
    applyStimulus(16'h1234, 16'h5678, 1'b0, 0, c, lat);
    checkOutput("exact_seq_01", {seq_a[0], seq_b[0], seq_a[1], seq_b[1]}, 32'h3478_3456);
    checkOutput("exact_seq_23", {seq_a[2], seq_b[2], seq_a[3], seq_b[3]}, 32'h1278_1256);
    applyStimulus(16'h1234, 16'h5678, 1'b1, 0, c, lat);
    checkOutput("approx_seq", {seq_a[0], seq_b[0], seq_a[1], seq_b[1]}, 32'h3478_1256);

    applyStimulus(16'h1234, 16'h5678, 1'b0, 10, c, lat);
    checkOutput("backpressure_out_c_value", c, 32'h0626_0060);

    // Abort an exact multiply in phase 2, then confirm that nothing leaks out.
    @(negedge clk);
    in_a = 16'h1234; in_b = 16'h5678; in_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_phase2_mul", {16'h0, mul_a, mul_b}, 32'h0000_1278);
    rst = 1'b1;
    #1;
    checkOutput("abort_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_mul", {16'h0, mul_a, mul_b}, 32'h0);
    repeat (5) @(negedge clk);
    checkOutput("abort_no_result", 32'(out_valid), 32'd0);

    // An operand pair that arrives while reset is active must be ignored.
    rst = 1'b1; in_valid = 1'b1; in_a = 16'h0005; in_b = 16'h0007; in_mode = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid_ignored", 32'(out_valid), 32'd0);
    checkOutput("rst_valid_idle", 32'(in_ready), 32'd1);

    applyStimulus(16'h0002, 16'h0003, 1'b0, 0, c, lat);
    checkOutput("after_abort_out_c", c, 32'h0000_0006);
    checkOutput("after_abort_latency", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
